// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   pll_state_e : supervisor state encoding, also exported on state_o for debug
//   DEF_*       : parameter defaults for a 27 MHz reference clock
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 27000;  // 1 ms at 27 MHz
  localparam int DEF_STABLE_CYCLES = 2700;   // 100 us at 27 MHz
  localparam int DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic q_p0;
  logic q_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0 <= 1'b0;
      q_p1 <= 1'b0;
    end else begin
      q_p0 <= d;
      q_p1 <= q_p0;
    end
  end

  assign q = q_p1;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout,
// requires a run of consecutive locked cycles before releasing downstream
// reset, retries failed lock attempts and latches FAULT after MAX_RETRY.
//   clk         : free-running reference clock (also the PLL input clock)
//   rst_n       : asynchronous active-low reset
//   pll_lock    : PLL lock flag, asynchronous to clk
//   clear_fault : single-cycle request to leave FAULT
//   pll_reset   : active-high reset to the PLL
//   sys_rst_n   : active-low reset for logic on the PLL output clock
//   fault       : high while in FAULT
//   retry_cnt   : failed lock attempts since last RUN entry or fault clear
//   loss_cnt    : lock losses seen in RUN, saturating at 255
//   state_o     : current state encoding
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       clear_fault,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state_o
);

  // One phase counter is shared by RST_PLL, WAIT_LOCK and STABLE, since only
  // one of them is active at a time; it only ever counts up to PARAM-1.
  localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIM   = 4'(MAX_RETRY);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic [7:0]       loss_q, loss_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             fault_q, fault_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT_LOCK: begin
        // Lock is tested first so it wins over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RST_PLL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RST_PLL;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          state_d = ST_RST_PLL;
          retry_d = '0;
        end
      end
      default: state_d = ST_RST_PLL;
    endcase

    // Outputs are decoded from the next state so the registered copies
    // change on the same edge as the state itself.
    pll_reset_d = (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
    sys_rst_n_d = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign sys_rst_n = sys_rst_n_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state_o   = state_q;

endmodule
